// File: rtl/key_schedule_pkg.sv
// Shared AES-128 constants, types and the round-constant table used by the
// key schedule and the encryption datapath.
package key_schedule_pkg;

    localparam int         ROUNDS     = 10;
    localparam int         KEY_BITS   = 128;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef logic [0:KEY_BITS-1] round_key_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } ks_state_t;

    // Round constant byte for rounds 1..10; it lands in the MSB of the word.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[value];

endmodule

// File: rtl/key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-entry register
// table, streamed out as it is produced and randomly readable afterwards.
module key_schedule
    import key_schedule_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [0:127]     key,
    input  logic [3:0]       rd_round,
    output logic [0:127]     rd_key,
    output logic [0:127]     rk_out,
    output logic [3:0]       rk_round,
    output logic             rk_valid,
    output logic             busy,
    output logic             keys_ready
);

    ks_state_t  state, next_state;
    round_key_t rk_table [0:ROUNDS];
    round_key_t next_rk;
    logic [3:0] next_round;
    logic       accept_start;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_word, sub_word;
    logic [31:0] w0, w1, w2, w3;

    // During EXPAND rk_out always mirrors table entry r-1, so it feeds the round logic.
    assign p0 = rk_out[0:31];
    assign p1 = rk_out[32:63];
    assign p2 = rk_out[64:95];
    assign p3 = rk_out[96:127];

    assign rot_word = {p3[23:0], p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .value(rot_word[8*i +: 8]),
            .subst(sub_word[8*i +: 8])
        );
    end

    assign next_round = rk_round + 4'd1;
    assign w0         = p0 ^ sub_word ^ {rcon(next_round), 24'h000000};
    assign w1         = p1 ^ w0;
    assign w2         = p2 ^ w1;
    assign w3         = p3 ^ w2;
    assign next_rk    = {w0, w1, w2, w3};

    assign accept_start = start && (state != EXPAND);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = EXPAND;
            EXPAND:     if (rk_round == LAST_ROUND) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // Status flags follow the registered state, so they change on the same edges.
    assign busy       = (state == EXPAND);
    assign rk_valid   = (state == EXPAND);
    assign keys_ready = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_key   <= '0;
            rk_out   <= '0;
            rk_round <= '0;
            for (int i = 0; i <= ROUNDS; i++) begin
                rk_table[i] <= '0;
            end
        end else begin
            rd_key <= (rd_round <= LAST_ROUND) ? rk_table[rd_round] : '0;
            if (accept_start) begin
                rk_table[0] <= key;
                rk_out      <= key;
                rk_round    <= '0;
            end else if (state == EXPAND && rk_round != LAST_ROUND) begin
                rk_table[next_round] <= next_rk;
                rk_out               <= next_rk;
                rk_round             <= next_round;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: word-level FIPS-197 expansion model
// plus a per-cycle behavioural model of the streaming/table interface.
module tb_key_schedule;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [0:127] key;
    logic [3:0]   rd_round;
    logic [0:127] rd_key;
    logic [0:127] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         busy;
    logic         keys_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic checking = 1'b0;

    logic [7:0]   sbox_tab [0:255];

    logic [0:127] m_key;
    logic [0:127] m_tbl [0:10];
    logic [0:127] m_rd;
    logic [0:127] m_out;
    logic [3:0]   m_round;
    logic         m_valid;
    logic         m_busy;
    logic         m_ready;
    int           m_pos;

    localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [0:127] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_schedule dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .key(key),
        .rd_round(rd_round),
        .rd_key(rd_key),
        .rk_out(rk_out),
        .rk_round(rk_round),
        .rk_valid(rk_valid),
        .busy(busy),
        .keys_ready(keys_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Textbook FIPS-197 word recurrence, returning round key r.
    function automatic logic [0:127] round_key(input logic [0:127] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [0:127] random128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-level reference: an expansion position walks 0..10, then one edge to finish.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= 10; i++) m_tbl[i] = '0;
            m_rd = '0; m_out = '0; m_round = '0;
            m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b0; m_pos = -1;
        end else begin
            m_rd = (rd_round <= 4'd10) ? m_tbl[rd_round] : '0;
            if (m_pos >= 0 && m_pos < 10) begin
                m_pos++;
                m_tbl[m_pos] = round_key(m_key, m_pos);
                m_out   = m_tbl[m_pos];
                m_round = 4'(m_pos);
            end else if (m_pos == 10) begin
                m_pos = -1; m_valid = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
            end else if (start) begin
                m_key = key; m_tbl[0] = key; m_out = key; m_round = '0;
                m_pos = 0; m_valid = 1'b1; m_busy = 1'b1; m_ready = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            check_output("rd_key", rd_key, m_rd);
            check_output("rk_out", rk_out, m_out);
            check_output("rk_round", {124'h0, rk_round}, {124'h0, m_round});
            check_output("rk_valid", {127'h0, rk_valid}, {127'h0, m_valid});
            check_output("busy", {127'h0, busy}, {127'h0, m_busy});
            check_output("keys_ready", {127'h0, keys_ready}, {127'h0, m_ready});
        end
    end

    task automatic check_all_zero(input string tag);
        check_output({tag, " rd_key"}, rd_key, '0);
        check_output({tag, " rk_out"}, rk_out, '0);
        check_output({tag, " rk_round"}, {124'h0, rk_round}, '0);
        check_output({tag, " rk_valid"}, {127'h0, rk_valid}, '0);
        check_output({tag, " busy"}, {127'h0, busy}, '0);
        check_output({tag, " keys_ready"}, {127'h0, keys_ready}, '0);
    endtask

    task automatic apply_stimulus(input logic [0:127] k);
        @(negedge clock);
        key   = k;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        key   = random128();
    endtask

    // Full expansion: rounds must step 0..10 and keys_ready rise on the 12th edge counting the start edge.
    task automatic run_expansion(input logic [0:127] k, input logic [0:127] exp1,
                                 input logic [0:127] exp10, input string tag);
        logic [0:127] got1 = '0;
        logic [0:127] got10 = '0;
        apply_stimulus(k);
        check_output({tag, " round0"}, rk_out, k);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clock);
            if (i <= 10) begin
                check_output({tag, " rk_round step"}, {124'h0, rk_round}, 128'(i));
                if (i == 1)  got1  = rk_out;
                if (i == 10) got10 = rk_out;
            end
            if (i == 10) check_output({tag, " ready early"}, {127'h0, keys_ready}, '0);
            if (i == 11) check_output({tag, " ready"}, {127'h0, keys_ready}, 128'h1);
        end
        check_output({tag, " round1"}, got1, exp1);
        check_output({tag, " round10"}, got10, exp10);
    endtask

    initial begin
        logic [0:127] k;
        logic [7:0] inv;
        logic [7:0] b;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            end
            b = inv;
            sbox_tab[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        reset_n = 1'b0; start = 1'b0; key = '0; rd_round = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n  = 1'b1;
        checking = 1'b1;

        run_expansion(FIPS_KEY, FIPS_R1, FIPS_R10, "fips");
        run_expansion('0, ZERO_R1, ZERO_R10, "zero");

        // A second start partway through must not disturb the running expansion.
        apply_stimulus(FIPS_KEY);
        repeat (5) @(negedge clock);
        key   = 128'h00112233445566778899aabbccddeeff;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check_output("ignore start round", {124'h0, rk_round}, 128'd10);
        check_output("ignore start r10", rk_out, FIPS_R10);
        @(negedge clock);
        check_output("ignore start ready", {127'h0, keys_ready}, 128'h1);

        // Asynchronous reset in the middle of round 4.
        apply_stimulus(FIPS_KEY);
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async reset");
        @(negedge clock);
        #2 reset_n = 1'b1;
        rd_round = 4'd1;
        @(negedge clock);
        @(negedge clock);
        check_output("post reset rd1", rd_key, '0);
        check_output("post reset ready", {127'h0, keys_ready}, '0);

        // Random reads of a stored schedule in DONE, then restart.
        k = random128();
        run_expansion(k, round_key(k, 1), round_key(k, 10), "rand");
        for (int i = 0; i <= 11; i++) begin
            @(negedge clock);
            rd_round = (i == 11) ? 4'd15 : 4'(i);
            @(negedge clock);
            check_output("done read", rd_key, (i == 11) ? '0 : round_key(k, i));
        end
        apply_stimulus(random128());
        check_output("restart ready", {127'h0, keys_ready}, '0);
        check_output("restart busy", {127'h0, busy}, 128'h1);
        repeat (12) @(negedge clock);

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            key      = random128();
            rd_round = 4'($urandom_range(0, 15));
            start    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  pulse, request expansion of key.
REQ-004 SHALL have port: key  input  [0:127]  AES-128 cipher key, bit 0 = MSB of byte 0.
REQ-005 SHALL have port: rd_round  input  4  round-key index for random read, 0..10.
REQ-006 SHALL have port: rd_key  output  [0:127]  round key selected by rd_round, registered.
REQ-007 SHALL have port: rk_out  output  [0:127]  streamed round key, registered.
REQ-008 SHALL have port: rk_round  output  4  index of rk_out.
REQ-009 SHALL have port: rk_valid  output  1  rk_out/rk_round valid this cycle.
REQ-010 SHALL have port: busy  output  1  expansion in progress.
REQ-011 SHALL have port: keys_ready  output  1  all 11 round keys stored and stable.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1 at an edge, latch key into table entry 0, drive rk_out=key, rk_round=0, rk_valid=1, clear keys_ready, set busy, enter EXPAND.
REQ-014 SHALL, in EXPAND, compute round r (1..10) from entry r-1 in one cycle: w0=p0^SubWord(RotWord(p3))^Rcon[r], w1=p1^w0, w2=p2^w1, w3=p3^w2.
REQ-015 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the most significant byte, zero elsewhere.
REQ-016 SHALL write round r to table entry r and drive rk_out, rk_round=r, rk_valid=1 on the same edge; rounds 0..10 appear on 11 consecutive cycles.
REQ-017 SHALL, on the edge after round 10 is output, deassert rk_valid and busy, assert keys_ready, enter DONE.
REQ-018 SHALL ignore start while in EXPAND; the current expansion completes unchanged.
REQ-019 SHALL sample key only on the start edge; later key changes do not affect the expansion in progress.
REQ-020 SHALL present rd_key one cycle after rd_round is sampled, in every state; rd_round > 10 returns all zeros.
REQ-021 SHALL keep table contents unchanged in DONE until the next accepted start.
REQ-022 SHALL hold rk_out and rk_round at their last values when rk_valid=0.

Reset
REQ-023 SHALL, on reset_n low, immediately force state IDLE, busy=0, keys_ready=0, rk_valid=0, rk_out=0, rk_round=0, rd_key=0, all 11 table entries=0.
REQ-024 SHALL, on reset asserted mid-EXPAND, abandon the expansion; after release keys_ready stays 0 until a new start completes.

Structure
REQ-025 SHALL take the round count (10), key width (128), and Rcon table from a shared AES package also used by Encryption.
REQ-026 SHALL instantiate four copies of one combinational sub-module, sbox (byte in, byte out), for SubWord; the sbox is shareable with Encryption.
REQ-027 SHALL store round keys in an 11-entry by 128-bit register array, with no memory macro.

Verification
REQ-028 SHALL check the FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6, with keys_ready 12 cycles after start.
REQ-029 SHALL check the all-zero key -> round 1 62636363626363636263636362636363, round 10 b4ef5bcb3e92e21123e951cf6f8f188e, and rk_round stepping 0..10 on consecutive cycles.
REQ-030 SHALL check that a start pulse at round 5 with a different key is ignored, producing the unchanged round-10 result.
REQ-031 SHALL check that reset_n pulsed low at round 4 zeroes all outputs asynchronously, and rd_round=1 then reads 0.
REQ-032 SHALL check in DONE that rd_round=0..10 returns the stored keys with 1-cycle latency, rd_round=15 returns 0, and a new start clears keys_ready on the same edge.
